axi_burst_initiator: RTL
========================

Name:
axi_burst_initiator

Overview:
Synthesizable AXI4 initiator that turns single 128-bit store/fetch requests into one INCR burst of 128/WIDTH beats on the axi_ddr3_lite AXI slave port. It is the hardware counterpart of the bench store/fetch tasks and carries one transaction at a time. Fixed AXI fields come from the shared package and are tied at top level: ID 0, burst INCR, len 128/WIDTH-1.

Parameters:
WIDTH, 32, AXI data width; legal values 32, 64, 128; BEATS = 128/WIDTH.
ADDRS, 32, AXI address width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
req_write_i  in  1  1 = store, 0 = fetch
req_addr_i  in  ADDRS  byte address; bits [3:0] ignored
req_mask_i  in  16  byte enables for the store
req_data_i  in  128  store data; bits [7:0] are byte 0
rsp_valid_o  out  1  one-cycle completion pulse
rsp_error_o  out  1  transaction error; valid with rsp_valid_o
rsp_data_o  out  128  fetch data; valid with rsp_valid_o; holds until the next fetch
axi_awvalid_o  out  1  write address valid
axi_awready_i  in  1  write address ready
axi_awaddr_o  out  ADDRS  16-byte-aligned write address
axi_wvalid_o  out  1  write data valid
axi_wready_i  in  1  write data ready
axi_wlast_o  out  1  final write beat
axi_wstrb_o  out  WIDTH/8  write strobes for the current beat
axi_wdata_o  out  WIDTH  write data for the current beat
axi_bvalid_i  in  1  write response valid
axi_bready_o  out  1  write response ready
axi_bresp_i  in  2  write response code
axi_arvalid_o  out  1  read address valid
axi_arready_i  in  1  read address ready
axi_araddr_o  out  ADDRS  16-byte-aligned read address
axi_rvalid_i  in  1  read data valid
axi_rready_o  out  1  read data ready
axi_rlast_i  in  1  final read beat
axi_rresp_i  in  2  read response code
axi_rdata_i  in  WIDTH  read data

Behaviour:
- Reset: every valid/ready output, rsp_error_o and the beat counter go to 0; state goes to IDLE. A reset mid-burst abandons the transaction; outputs are low on the edge after reset. rsp_data_o resets to 0.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE. All outputs are registered.
- IDLE: on req_valid_i & req_ready_o, latch addr (low 4 bits cleared), mask and data, clear the error flag, then go to WADDR or RADDR.
- WADDR: awvalid held until the awready handshake, then go to WDATA. The W channel never starts before the AW handshake.
- WDATA: beat n carries data[n*WIDTH +: WIDTH] and strb mask[n*WIDTH/8 +: WIDTH/8], least-significant first. The next beat is presented on the cycle after each wready handshake, so beats can run back to back. wlast is high only on beat BEATS-1. After the last handshake go to WRESP.
- WRESP: bready is high. On bvalid, set the error flag if bresp != 0, then go to DONE.
- RADDR: mirrors WADDR on the AR channel, then go to RDATA.
- RDATA: rready is high. Each rvalid shifts rdata in from the top, so beat 0 lands in bits [WIDTH-1:0].
- rlast before beat BEATS-1: flag error and go to DONE.
- Beat BEATS-1 without rlast: flag error and keep accepting beats until rlast.
- Any rresp != 0 sets the error flag.
- DONE: rsp_valid_o is high for exactly one cycle, then return to IDLE.
- Best-case latency with slave ready always high, request accept to rsp_valid_o: store = 1 + 1 + BEATS + 1 + 1 cycles; fetch = 1 + 1 + BEATS + 1 cycles.
- req_valid_i held in DONE or busy states is ignored until IDLE.

Decomposition:
Shared package axi_ddr3_pkg holds the BRESP/RRESP codes, the fixed ID/INCR/len constants and the state encoding. One sub-module, axi_beat_packer, provides the 128-bit-to-beat serializer and the beat-to-128-bit deserializer with the beat counter. Everything else is a single FSM file.

Test Plan:
- Store addr 0x0, data 128'hffeeddccbbaa99887766554433221100, mask 16'hFFFF -> 4 beats 0x33221100, 0x77665544, 0xbbaa9988, 0xffeeddcc; wlast on beat 3 only; bresp 0 gives rsp_valid_o with rsp_error_o=0. Then a fetch of 0x0 returns the same 128 bits.
- Store addr 0x13, mask 16'h00F0 -> awaddr 0x10; wstrb sequence 0x0, 0xF, 0x0, 0x0.
- Fetch with rvalid toggling every other cycle and awready/arready delayed 5 cycles -> correct data; req_ready_o low throughout; exactly one rsp_valid_o pulse.
- Fetch where rlast is asserted on beat 2 -> rsp_error_o=1. Separately, store with bresp=2'b10 -> rsp_error_o=1.
- Assert reset during WDATA beat 2 -> wvalid_o low on the next edge, state IDLE, req_ready_o high one cycle after reset deasserts.

Source files
------------

// File: rtl/axi_ddr3_pkg.sv
// Shared AXI constants and FSM encoding for the axi_ddr3_lite initiator side.
package axi_ddr3_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam logic [3:0] AxiId        = 4'd0;
    localparam logic [1:0] AxiBurstIncr = 2'b01;

    // Wide enough that an over-long read burst cannot wrap before the error sticks.
    localparam int unsigned BeatCntW = 8;

    // AXI LEN field for one 128-bit transfer at the given data width.
    function automatic logic [7:0] axi_len(input int unsigned width);
        return 8'(128 / width - 1);
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_t;

endpackage

// File: rtl/axi_beat_packer.sv
// Splits a 128-bit word into WIDTH-bit write beats and gathers read beats back
// into a 128-bit word; owns the shared beat counter.
module axi_beat_packer
    import axi_ddr3_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [127:0]          load_data,
    input  logic [15:0]           load_mask,
    input  logic                  w_advance,
    input  logic                  r_shift,
    input  logic [WIDTH-1:0]      r_data,
    output logic [WIDTH-1:0]      w_data,
    output logic [WIDTH/8-1:0]    w_strb,
    output logic                  w_last,
    output logic [BeatCntW-1:0]   beat_cnt,
    output logic [127:0]          r_word
);

    localparam int unsigned StrbW = WIDTH / 8;
    localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(axi_len(WIDTH));

    logic [127:0]          w_word_q;
    logic [15:0]           w_mask_q;
    logic                  w_last_q;
    logic [BeatCntW-1:0]   cnt_q;
    logic [BeatCntW-1:0]   cnt_inc;
    logic [127:0]          r_word_q;
    logic [127:0]          r_word_next;

    assign cnt_inc = cnt_q + BeatCntW'(1);

    // New beats enter at the top so beat 0 ends up in the low bits.
    always_comb begin
        r_word_next = r_word_q >> WIDTH;
        r_word_next[127 -: WIDTH] = r_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_word_q <= '0;
            w_mask_q <= '0;
            w_last_q <= 1'b0;
            cnt_q    <= '0;
            r_word_q <= '0;
        end else if (load) begin
            w_word_q <= load_data;
            w_mask_q <= load_mask;
            w_last_q <= (LastBeat == '0);
            cnt_q    <= '0;
        end else if (w_advance) begin
            w_word_q <= w_word_q >> WIDTH;
            w_mask_q <= w_mask_q >> StrbW;
            w_last_q <= (cnt_inc == LastBeat);
            cnt_q    <= cnt_inc;
        end else if (r_shift) begin
            r_word_q <= r_word_next;
            cnt_q    <= cnt_inc;
        end
    end

    assign w_data   = w_word_q[WIDTH-1:0];
    assign w_strb   = w_mask_q[StrbW-1:0];
    assign w_last   = w_last_q;
    assign beat_cnt = cnt_q;
    assign r_word   = r_word_q;

endmodule

// File: rtl/axi_burst_initiator.sv
// AXI4 initiator: one 128-bit store or fetch becomes a single INCR burst of
// 128/WIDTH beats; one transaction in flight, all outputs registered.
module axi_burst_initiator
    import axi_ddr3_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDRS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [ADDRS-1:0]    req_addr_i,
    input  logic [15:0]         req_mask_i,
    input  logic [127:0]        req_data_i,
    output logic                rsp_valid_o,
    output logic                rsp_error_o,
    output logic [127:0]        rsp_data_o,
    output logic                axi_awvalid_o,
    input  logic                axi_awready_i,
    output logic [ADDRS-1:0]    axi_awaddr_o,
    output logic                axi_wvalid_o,
    input  logic                axi_wready_i,
    output logic                axi_wlast_o,
    output logic [WIDTH/8-1:0]  axi_wstrb_o,
    output logic [WIDTH-1:0]    axi_wdata_o,
    input  logic                axi_bvalid_i,
    output logic                axi_bready_o,
    input  logic [1:0]          axi_bresp_i,
    output logic                axi_arvalid_o,
    input  logic                axi_arready_i,
    output logic [ADDRS-1:0]    axi_araddr_o,
    input  logic                axi_rvalid_i,
    output logic                axi_rready_o,
    input  logic                axi_rlast_i,
    input  logic [1:0]          axi_rresp_i,
    input  logic [WIDTH-1:0]    axi_rdata_i
);

    localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(axi_len(WIDTH));
    localparam logic [ADDRS-1:0]    LineMask = {{(ADDRS-4){1'b1}}, 4'b0000};

    state_t               state_q, state_d;
    logic                 err_q, err_d;
    logic [ADDRS-1:0]     addr_q;
    logic                 req_ready_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic                 arvalid_q;
    logic                 rready_q;
    logic                 rsp_valid_q;

    logic                 load;
    logic                 w_advance;
    logic                 r_shift;
    logic                 w_last;
    logic [BeatCntW-1:0]  beat_cnt;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        load      = 1'b0;
        w_advance = 1'b0;
        r_shift   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_q) begin
                    load    = 1'b1;
                    err_d   = 1'b0;
                    state_d = req_write_i ? StWaddr : StRaddr;
                end
            end
            StWaddr: begin
                if (awvalid_q && axi_awready_i) begin
                    state_d = StWdata;
                end
            end
            StWdata: begin
                if (wvalid_q && axi_wready_i) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        state_d = StWresp;
                    end
                end
            end
            StWresp: begin
                if (bready_q && axi_bvalid_i) begin
                    if (axi_bresp_i != RespOkay) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
            StRaddr: begin
                if (arvalid_q && axi_arready_i) begin
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (rready_q && axi_rvalid_i) begin
                    r_shift = 1'b1;
                    if (axi_rresp_i != RespOkay) begin
                        err_d = 1'b1;
                    end
                    if (axi_rlast_i) begin
                        // A short burst is an error; an over-long one was flagged already.
                        if (beat_cnt != LastBeat) begin
                            err_d = 1'b1;
                        end
                        state_d = StDone;
                    end else if (beat_cnt >= LastBeat) begin
                        err_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so each one is a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            if (load) begin
                addr_q <= req_addr_i & LineMask;
            end
            req_ready_q <= (state_d == StIdle);
            awvalid_q   <= (state_d == StWaddr);
            wvalid_q    <= (state_d == StWdata);
            bready_q    <= (state_d == StWresp);
            arvalid_q   <= (state_d == StRaddr);
            rready_q    <= (state_d == StRdata);
            rsp_valid_q <= (state_d == StDone);
        end
    end

    axi_beat_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (req_data_i),
        .load_mask (req_mask_i),
        .w_advance (w_advance),
        .r_shift   (r_shift),
        .r_data    (axi_rdata_i),
        .w_data    (axi_wdata_o),
        .w_strb    (axi_wstrb_o),
        .w_last    (w_last),
        .beat_cnt  (beat_cnt),
        .r_word    (rsp_data_o)
    );

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_error_o   = err_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wlast_o   = w_last;
    assign axi_bready_o  = bready_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    assign axi_rready_o  = rready_q;

endmodule
